// File: rtl/traffic_pkg.sv
// Shared types for the intersection: pedestrian FSM states and the lamp
// encoding used by the traffic light controller. The helper flags any
// cycle where more than one lamp is lit.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    WALK    = 2'd2,
    CLEAR   = 2'd3
  } ped_state_e;

  typedef enum logic [1:0] {
    LAMP_OFF    = 2'd0,
    LAMP_RED    = 2'd1,
    LAMP_YELLOW = 2'd2,
    LAMP_GREEN  = 2'd3
  } lamp_e;

  // True when two or more lamps are on at once.
  function automatic logic lamp_conflict(input logic r, input logic y, input logic g);
    return (r & y) | (r & g) | (y & g);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and a
// one-cycle pulse on the debounced rising edge.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button
//   press    : registered 1-cycle pulse, 2 + DEBOUNCE_CYC cycles after a clean edge
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  import traffic_pkg::*;

  localparam logic [7:0] CNT_LIM = 8'(DEBOUNCE_CYC - 1);

  logic [1:0] sync_q, sync_d;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    // Counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts it.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LIM) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      press_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller beside the traffic light controller.
// Debounces the button, requests a red phase via pass_request, and drives
// WALK / flashing DON'T-WALK from the lamp inputs and countdown.
//   clk, rst              : clock, synchronous active-high reset
//   btn                   : raw pedestrian button
//   red, yellow, green    : lamps from the traffic controller
//   clock                 : controller countdown (unsigned)
//   pass_request          : registered request to the controller
//   walk, dont_walk       : pedestrian lamps
//   pending               : request latched, waiting for the walk phase
//   wait_cnt              : cycles spent pending for the latest request (saturating)
//   fault                 : sticky multi-lamp fault
module ped_crossing_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CLEAR_TH     = 3,
  parameter int FLASH_DIV    = 2,
  parameter int WAIT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              red,
  input  logic              yellow,
  input  logic              green,
  input  logic [7:0]        clock,
  output logic              pass_request,
  output logic              walk,
  output logic              dont_walk,
  output logic              pending,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              fault
);
  import traffic_pkg::*;

  localparam logic [7:0] CLEAR_TH_L = 8'(CLEAR_TH);
  localparam logic [7:0] FLASH_LIM  = 8'(FLASH_DIV - 1);

  logic              press, conflict, red_rise;
  ped_state_e        state_q, state_d;
  logic              red_d_q, pr_q, pr_d, walk_q, walk_d, dw_q, dw_d;
  logic              pend_q, pend_d, fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        flash_q, flash_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  assign conflict = lamp_conflict(red, yellow, green);
  assign red_rise = red & ~red_d_q;

  always_comb begin
    state_d = state_q;
    pr_d    = 1'b0;
    wait_d  = wait_q;
    fault_d = fault_q;
    flash_d = flash_q;
    dw_d    = 1'b1;

    if (conflict) begin
      fault_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (press && !fault_q) begin
            state_d = PENDING;
            wait_d  = '0;
          end
        end
        PENDING: begin
          if (wait_q != '1) wait_d = wait_q + 1'b1;
          if (red_rise) state_d = WALK;
          else          pr_d    = green;
        end
        WALK: begin
          if (clock <= CLEAR_TH_L || !red) state_d = CLEAR;
        end
        CLEAR: begin
          if (!red) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs follow the next state so they are registered alongside it.
    walk_d = (state_d == WALK);
    pend_d = (state_d == PENDING);
    if (state_d == WALK) begin
      dw_d = 1'b0;
    end else if (state_d == CLEAR) begin
      if (state_q != CLEAR) begin
        // Entering CLEAR: start steady-on, restart the flash timer.
        dw_d    = 1'b1;
        flash_d = '0;
      end else if (flash_q == FLASH_LIM) begin
        dw_d    = ~dw_q;
        flash_d = '0;
      end else begin
        dw_d    = dw_q;
        flash_d = flash_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      red_d_q <= 1'b0;
      pr_q    <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      fault_q <= 1'b0;
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      red_d_q <= red;
      pr_q    <= pr_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      flash_q <= flash_d;
    end
  end

  assign pass_request = pr_q;
  assign walk         = walk_q;
  assign dont_walk    = dw_q;
  assign pending      = pend_q;
  assign wait_cnt     = wait_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
module tb_ped_crossing_ctrl;
  logic       clk = 1'b0;
  logic       rst, btn, red, yellow, green;
  logic [7:0] clock;
  logic       pass_request, walk, dont_walk, pending, fault;
  logic [3:0] wait_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ped_crossing_ctrl #(.DEBOUNCE_CYC(4), .CLEAR_TH(3), .FLASH_DIV(2), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .red(red), .yellow(yellow), .green(green),
    .clock(clock), .pass_request(pass_request), .walk(walk), .dont_walk(dont_walk),
    .pending(pending), .wait_cnt(wait_cnt), .fault(fault)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1; btn = 0; red = 0; yellow = 0; green = 0; clock = 8'd0;
    tick(2);
    rst = 0;
    checks++; if ({pass_request, walk, dont_walk, pending, fault} !== 5'b00100) begin errors++; $display("FAIL reset_outs got %b exp 00100", {pass_request, walk, dont_walk, pending, fault}); end
    checks++; if (wait_cnt !== 4'd0) begin errors++; $display("FAIL reset_wait got %0d exp 0", wait_cnt); end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(2);
      checks++; if (pending !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL bounce_%0d pending=%b dw=%b exp 0 1", i, pending, dont_walk); end
    end
    btn = 0;
    tick(8);
    checks++; if (pending !== 1'b0 || walk !== 1'b0) begin errors++; $display("FAIL bounce_end pending=%b walk=%b exp 0 0", pending, walk); end
  endtask

  task automatic test_clean_press;
    green = 1; clock = 8'd40; btn = 1;
    tick(6);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL press_early pending=%b exp 0", pending); end
    tick(1);
    checks++; if (pending !== 1'b1 || wait_cnt !== 4'd0 || pass_request !== 1'b0) begin errors++; $display("FAIL press_lat pend=%b wait=%0d pr=%b exp 1 0 0", pending, wait_cnt, pass_request); end
    tick(1);
    checks++; if (pass_request !== 1'b1 || wait_cnt !== 4'd1) begin errors++; $display("FAIL press_req pr=%b wait=%0d exp 1 1", pass_request, wait_cnt); end
    tick(2);
    btn = 0;
    green = 0; yellow = 1;
    tick(1);
    checks++; if (pass_request !== 1'b0 || pending !== 1'b1 || wait_cnt !== 4'd4) begin errors++; $display("FAIL press_yel pr=%b pend=%b wait=%0d exp 0 1 4", pass_request, pending, wait_cnt); end
    yellow = 0; red = 1; clock = 8'd10;
    tick(1);
    checks++; if ({walk, dont_walk, pending, pass_request} !== 4'b1000) begin errors++; $display("FAIL press_walk got %b exp 1000", {walk, dont_walk, pending, pass_request}); end
    checks++; if (wait_cnt !== 4'd5) begin errors++; $display("FAIL press_wait got %0d exp 5", wait_cnt); end
    clock = 8'd9;
    tick(1);
    checks++; if (wait_cnt !== 4'd5 || walk !== 1'b1) begin errors++; $display("FAIL press_frozen wait=%0d walk=%b exp 5 1", wait_cnt, walk); end
  endtask

  task automatic test_walk_clear;
    for (int c = 8; c >= 4; c--) begin
      clock = 8'(c);
      tick(1);
      checks++; if (walk !== 1'b1 || dont_walk !== 1'b0) begin errors++; $display("FAIL walk_c%0d walk=%b dw=%b exp 1 0", c, walk, dont_walk); end
    end
    clock = 8'd3;
    tick(1);
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL clear_entry walk=%b dw=%b exp 0 1", walk, dont_walk); end
    begin
      logic [3:0] pat;
      pat = 4'b1001;  // following entry: 1,0,0,1 (msb first)
      for (int k = 3; k >= 0; k--) begin
        clock = 8'(k);
        tick(1);
        checks++; if (dont_walk !== pat[k]) begin errors++; $display("FAIL flash_%0d got %b exp %b", 3 - k, dont_walk, pat[k]); end
      end
    end
    red = 0;
    tick(1);
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL clear_idle walk=%b dw=%b exp 0 1", walk, dont_walk); end
    tick(3);
    checks++; if (dont_walk !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL idle_steady dw=%b pend=%b exp 1 0", dont_walk, pending); end
  endtask

  task automatic test_press_red;
    red = 1; clock = 8'd30; btn = 1;
    tick(7);
    checks++; if (pending !== 1'b1 || wait_cnt !== 4'd0 || walk !== 1'b0) begin errors++; $display("FAIL red_press pend=%b wait=%0d walk=%b exp 1 0 0", pending, wait_cnt, walk); end
    btn = 0;
    tick(6);
    btn = 1;
    tick(7);
    checks++; if (wait_cnt !== 4'd13 || pending !== 1'b1 || walk !== 1'b0) begin errors++; $display("FAIL second_press wait=%0d pend=%b walk=%b exp 13 1 0", wait_cnt, pending, walk); end
    btn = 0; red = 0;
    tick(1);
    checks++; if (walk !== 1'b0 || pending !== 1'b1) begin errors++; $display("FAIL red_fall walk=%b pend=%b exp 0 1", walk, pending); end
    red = 1; clock = 8'd10;
    tick(1);
    checks++; if (walk !== 1'b1 || wait_cnt !== 4'd15) begin errors++; $display("FAIL red_rewalk walk=%b wait=%0d exp 1 15", walk, wait_cnt); end
  endtask

  task automatic test_fault;
    green = 1;
    tick(1);
    green = 0; red = 0;
    checks++; if ({fault, walk, dont_walk, pending, pass_request} !== 5'b10100) begin errors++; $display("FAIL fault_set got %b exp 10100", {fault, walk, dont_walk, pending, pass_request}); end
    tick(8);
    btn = 1;
    tick(10);
    checks++; if (fault !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL fault_press fault=%b pend=%b exp 1 0", fault, pending); end
    btn = 0;
    rst = 1;
    tick(1);
    rst = 0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_rst got %b exp 0", fault); end
  endtask

  task automatic test_saturate_reset;
    red = 0; yellow = 0; green = 0; btn = 1;
    tick(7);
    btn = 0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL sat_pend got %b exp 1", pending); end
    tick(20);
    checks++; if (wait_cnt !== 4'd15 || pass_request !== 1'b0) begin errors++; $display("FAIL sat_wait wait=%0d pr=%b exp 15 0", wait_cnt, pass_request); end
    tick(1);
    checks++; if (wait_cnt !== 4'd15 || pending !== 1'b1) begin errors++; $display("FAIL sat_hold wait=%0d pend=%b exp 15 1", wait_cnt, pending); end
    rst = 1;
    tick(1);
    checks++; if ({pass_request, walk, dont_walk, pending, fault} !== 5'b00100 || wait_cnt !== 4'd0) begin errors++; $display("FAIL midop_rst got %b wait=%0d exp 00100 0", {pass_request, walk, dont_walk, pending, fault}, wait_cnt); end
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_clean_press;
    test_walk_clear;
    test_press_red;
    test_fault;
    test_saturate_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
